rfid_cmd_tx: RTL and testbench
==============================

// Module: rfid_cmd_tx
// PURPOSE
// - UART transmitter that builds and sends command frames to the UHF RFID reader module (host -> reader).
// - It is the outbound counterpart of the RFID frame receiver and shares the same baud_tick.
// - Frame layout: BB, type, cmd, PL_H=0x00, PL_L, payload[0..PL_L-1], checksum, 7E.
// - checksum = sum of type, cmd, PL_H, PL_L and all payload bytes, mod 256.
// PARAMETERS
// - MAX_PL      4      maximum payload bytes per frame (1..16)
// - POLL_TICKS  24000  baud ticks of idle time between auto-polls (only used under RFID_AUTO_POLL_EN)
// PORTS
// - clk        in   1          system clock
// - rst        in   1          synchronous, active-low reset
// - baud_tick  in   1          one-clk pulse per bit period, shared with the receiver
// - start      in   1          one-clk request to send a frame; sampled only in IDLE
// - msg_type   in   8          frame type byte (0x00 = command)
// - cmd_code   in   8          command byte (e.g. 0x22 = single poll)
// - pl_len     in   5          payload length; values above MAX_PL are clamped to MAX_PL
// - payload    in   8*MAX_PL   payload byte k sits in bits [8k+7:8k]
// - auto_poll  in   1          enables periodic poll; ignored when the macro is not defined
// - txd        out  1          serial line: idle high, 8N1, LSB first
// - busy       out  1          high while a frame is in progress
// - done       out  1          one-clk pulse when the last stop bit completes
// BEHAVIOUR
// - Reset values: txd=1, busy=0, done=0, FSM=IDLE, all counters 0.
// - Reset mid-frame aborts the frame; txd=1 on the clock after reset.
// - FSM states: IDLE -> WAIT_TICK -> START -> DATA -> STOP, then either START (next byte) or IDLE.
// - IDLE, start=1: latch msg_type, cmd_code, clamped pl_len and payload; busy=1 next cycle; go to WAIT_TICK.
// - Inputs may change after the latch cycle.
// - txd changes only on clocks where baud_tick=1, so each bit lasts exactly one tick period.
// - First baud_tick after latch: txd=0 (start bit).
// - Next 8 ticks: data bits d0..d7. Next tick: txd=1 (stop bit).
// - Tick that ends the stop bit: send the next byte's start bit with no gap.
// - After the last byte, that tick instead asserts done for 1 clk, clears busy the same clk, and returns to IDLE.
// - Frame length = 10*(7+PL) ticks, measured from the start-bit edge to done.
// - Byte index: 5-bit counter 0..6+PL. Byte mux selects header, fields, payload[idx-5], checksum or 7E.
// - Checksum: 8-bit accumulator. Cleared on latch; adds each byte at index 1..4+PL as it is loaded.
// - Overflow discards the carry; the accumulated result is sent at index 5+PL.
// - start while busy, or in the same clk as done: ignored, no queueing.
// - start and baud_tick in the same clk in IDLE: latch only; the start bit goes out on the following tick.
// - pl_len=0: frame is 7 bytes; payload is ignored.
// CONFIGURATION
// - Macro RFID_AUTO_POLL_EN defined:
//   - While IDLE with auto_poll=1, a counter counts baud ticks.
//   - When it reaches POLL_TICKS, the block sends a single-poll frame BB 00 22 00 00 22 7E as if start were pulsed.
//   - The counter clears on any frame start, when auto_poll=0, and on reset.
//   - An external start in IDLE has priority and clears the counter.
// - Macro not defined: no counter logic; auto_poll unused; frames are sent only on start.
// TESTING
// - Baud: tick every 16 clk. start, type=00, cmd=22, len=0
//   -> bytes BB 00 22 00 00 22 7E; done 70 ticks after the first start bit; busy high throughout.
// - type=00, cmd=27, len=3, payload=22 00 0A
//   -> BB 00 27 00 03 22 00 0A 56 7E (checksum 0x56); 100 ticks.
// - Checksum wrap: cmd=FF, len=2, payload=FF FF
//   -> checksum FF (0x2FF mod 256); frame ends 7E.
// - len=9 with MAX_PL=4
//   -> PL_L byte = 04, 4 payload bytes sent, 11-byte frame.
// - start pulsed mid-frame -> ignored; rst=0 at byte 3 bit 4 -> next clk txd=1, busy=0, no done.
//   - After reset: a new start gives a clean full frame.
// - RFID_AUTO_POLL_EN, POLL_TICKS=50, auto_poll=1, no start
//   -> poll frame begins after 50 idle ticks and repeats 50 ticks after each done.
// - Checker: a UART decoder on txd compares the byte stream against a golden list.

Source files
------------

// File: rtl/rfid_cmd_tx.sv
// rfid_cmd_tx: UART transmitter for host -> UHF RFID reader command frames.
// Frame: BB, type, cmd, 00, PL_L, payload[0..PL_L-1], checksum, 7E.
// The checksum is the 8-bit sum of type, cmd, PL_H, PL_L and the payload bytes.
// Serial format is 8N1, LSB first. One bit lasts one baud_tick period.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active low
//   baud_tick  one-clk pulse per bit period, shared with the receiver
//   start      one-clk frame request, sampled only in IDLE
//   msg_type   frame type byte
//   cmd_code   command byte
//   pl_len     payload length, clamped to MAX_PL
//   payload    payload byte k in bits [8k+7:8k]
//   auto_poll  periodic single-poll enable (needs RFID_AUTO_POLL_EN)
//   txd        serial output, idles high
//   busy       high while a frame is in progress
//   done       one-clk pulse when the last stop bit completes
//
// Build option: define RFID_AUTO_POLL_EN to get the auto-poll timer.
// Without it, frames are sent only on start.

module rfid_cmd_tx #(
   parameter int MAX_PL     = 4,
   parameter int POLL_TICKS = 24000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  baud_tick,
   input  logic                  start,
   input  logic [7:0]            msg_type,
   input  logic [7:0]            cmd_code,
   input  logic [4:0]            pl_len,
   input  logic [8*MAX_PL-1:0]   payload,
   input  logic                  auto_poll,
   output logic                  txd,
   output logic                  busy,
   output logic                  done
);

   // state     | meaning
   // S_IDLE    | line idle; waiting for start or an auto-poll
   // S_WAIT    | frame latched; waiting for the tick that begins byte 0
   // S_START   | start bit of byte_q on the line
   // S_DATA    | data bit bit_q of byte_q on the line
   // S_STOP    | stop bit on the line; next tick loads the next byte or ends
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_DATA, S_STOP} state_t;

   localparam logic [4:0] MAX_PL_L = 5'(MAX_PL);

   state_t                state_q, state_d;
   logic [7:0]            type_q, type_d, cmd_q, cmd_d;
   logic [4:0]            len_q, len_d;
   logic [8*MAX_PL-1:0]   pl_q, pl_d;
   logic [4:0]            idx_q, idx_d;
   logic [2:0]            bit_q, bit_d;
   logic [7:0]            byte_q, byte_d;
   logic [7:0]            csum_q, csum_d;
   logic                  txd_q, txd_d, busy_q, busy_d, done_q, done_d;

   logic                  ext_start, poll_fire, launch;
   logic [4:0]            idx_inc, pidx;
   logic [7:0]            pl_byte, next_byte;
   logic [2:0]            bit_nxt;

   // A start coinciding with done is dropped, not queued.
   assign ext_start = start && (state_q == S_IDLE) && !done_q;
   assign launch    = ext_start || poll_fire;

`ifdef RFID_AUTO_POLL_EN
   localparam int PW = $clog2(POLL_TICKS + 1);
   logic [PW-1:0] poll_cnt_q, poll_cnt_d;

   always_comb begin
      poll_cnt_d = poll_cnt_q;
      poll_fire  = 1'b0;
      if (state_q != S_IDLE || !auto_poll || ext_start || done_q) begin
         poll_cnt_d = '0;
      end else if (baud_tick) begin
         if (poll_cnt_q == PW'(POLL_TICKS - 1)) begin
            poll_fire  = 1'b1;
            poll_cnt_d = '0;
         end else begin
            poll_cnt_d = poll_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) poll_cnt_q <= '0;
      else      poll_cnt_q <= poll_cnt_d;
   end
`else
   logic unused_auto_poll;
   assign unused_auto_poll = auto_poll | (POLL_TICKS < 1);
   assign poll_fire        = 1'b0;
`endif

   assign idx_inc = idx_q + 5'd1;
   assign pidx    = idx_inc - 5'd5;
   assign bit_nxt = bit_q + 3'd1;

   always_comb begin
      pl_byte = 8'h00;
      for (int k = 0; k < MAX_PL; k++) begin
         if (pidx == 5'(k)) pl_byte = pl_q[8*k +: 8];
      end
   end

   // Byte for index idx_inc; byte 0 (BB) is loaded at latch time.
   always_comb begin
      if (idx_inc == 5'd1)                next_byte = type_q;
      else if (idx_inc == 5'd2)           next_byte = cmd_q;
      else if (idx_inc == 5'd3)           next_byte = 8'h00;
      else if (idx_inc == 5'd4)           next_byte = {3'b000, len_q};
      else if (idx_inc <= len_q + 5'd4)   next_byte = pl_byte;
      else if (idx_inc == len_q + 5'd5)   next_byte = csum_q;
      else                                next_byte = 8'h7E;
   end

   always_comb begin
      state_d = state_q;
      type_d  = type_q;
      cmd_d   = cmd_q;
      len_d   = len_q;
      pl_d    = pl_q;
      idx_d   = idx_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      csum_d  = csum_q;
      txd_d   = txd_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (launch) begin
               state_d = S_WAIT;
               busy_d  = 1'b1;
               idx_d   = 5'd0;
               bit_d   = 3'd0;
               byte_d  = 8'hBB;
               csum_d  = 8'h00;
               if (ext_start) begin
                  type_d = msg_type;
                  cmd_d  = cmd_code;
                  len_d  = (pl_len > MAX_PL_L) ? MAX_PL_L : pl_len;
                  pl_d   = payload;
               end else begin
                  type_d = 8'h00;
                  cmd_d  = 8'h22;
                  len_d  = 5'd0;
                  pl_d   = '0;
               end
            end
         end
         S_WAIT: begin
            if (baud_tick) begin
               txd_d   = 1'b0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_tick) begin
               txd_d   = byte_q[0];
               bit_d   = 3'd0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_tick) begin
               if (bit_q == 3'd7) begin
                  txd_d   = 1'b1;
                  state_d = S_STOP;
               end else begin
                  txd_d = byte_q[bit_nxt];
                  bit_d = bit_nxt;
               end
            end
         end
         S_STOP: begin
            if (baud_tick) begin
               if (idx_q == len_q + 5'd6) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_inc;
                  byte_d  = next_byte;
                  txd_d   = 1'b0;
                  state_d = S_START;
                  if (idx_inc <= len_q + 5'd4) csum_d = csum_q + next_byte;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         type_q  <= 8'h00;
         cmd_q   <= 8'h00;
         len_q   <= 5'd0;
         pl_q    <= '0;
         idx_q   <= 5'd0;
         bit_q   <= 3'd0;
         byte_q  <= 8'h00;
         csum_q  <= 8'h00;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         type_q  <= type_d;
         cmd_q   <= cmd_d;
         len_q   <= len_d;
         pl_q    <= pl_d;
         idx_q   <= idx_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         csum_q  <= csum_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign txd  = txd_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_rfid_cmd_tx.sv
// Bench for rfid_cmd_tx in its default build (MAX_PL=4, no auto-poll).
// baud_tick pulses every 16 clk. A UART decoder on txd samples each bit in
// the middle of its period and compares the bytes against a golden list.
module tb_rfid_cmd_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        baud_tick = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  msg_type = 8'h00;
   logic [7:0]  cmd_code = 8'h00;
   logic [4:0]  pl_len = 5'd0;
   logic [31:0] payload = 32'h0;
   logic        auto_poll = 1'b0;
   logic        txd, busy, done;

   int n_chk  = 0;
   int n_fail = 0;
   int div    = 0;

   typedef struct {
      logic [7:0]       typ;
      logic [7:0]       cmd;
      logic [4:0]       len;
      logic [31:0]      pl;
      int               n;
      logic [0:10][7:0] exp;
   } vec_t;

   vec_t vecs[5];

   rfid_cmd_tx #(.MAX_PL(4), .POLL_TICKS(50)) dut (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .start(start),
      .msg_type(msg_type), .cmd_code(cmd_code), .pl_len(pl_len),
      .payload(payload), .auto_poll(auto_poll),
      .txd(txd), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(negedge clk);
         baud_tick = (div == 15);
         div = (div + 1) % 16;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Drives one start pulse at the current negedge; returns at the negedge after the latch edge.
   task automatic pulse_start(input vec_t v);
      msg_type = v.typ;
      cmd_code = v.cmd;
      pl_len   = v.len;
      payload  = v.pl;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      msg_type = 8'($urandom);
      cmd_code = 8'($urandom);
      pl_len   = 5'($urandom);
      payload  = $urandom;
   endtask

   // Decodes a whole frame from the current negedge and checks done timing.
   task automatic check_frame(input string tag, input vec_t v, input bit mid_start, output int lat);
      logic [7:0] got;
      int         frame_err;
      int         busy_err;
      lat = 0;
      frame_err = 0;
      busy_err = 0;
      while (txd !== 1'b0 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_start_seen"}, {31'd0, txd}, 32'd0);
      if (txd !== 1'b0) return;
      for (int b = 0; b < v.n; b++) begin
         got = 8'h00;
         repeat (8) @(negedge clk);
         if (txd !== 1'b0) frame_err++;
         for (int i = 0; i < 8; i++) begin
            if (mid_start && b == 2 && i == 3) begin
               start    = 1'b1;
               cmd_code = 8'h99;
               @(negedge clk);
               start    = 1'b0;
               repeat (15) @(negedge clk);
            end else begin
               repeat (16) @(negedge clk);
            end
            got[i] = txd;
            if (busy !== 1'b1) busy_err++;
         end
         repeat (16) @(negedge clk);
         if (txd !== 1'b1) frame_err++;
         if (done !== 1'b0) frame_err++;
         chk($sformatf("%s_byte%0d", tag, b), {24'd0, got}, {24'd0, v.exp[b]});
         repeat (8) @(negedge clk);
      end
      chk({tag, "_framing"}, frame_err, 0);
      chk({tag, "_busy_hold"}, busy_err, 0);
      chk({tag, "_done_at_end"}, {31'd0, done}, 32'd1);
      chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      if (mid_start) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_done_width"}, {31'd0, done}, 32'd0);
      chk({tag, "_txd_idle"}, {31'd0, txd}, 32'd1);
      if (mid_start) begin
         busy_err = 0;
         repeat (40) begin
            @(negedge clk);
            if (busy !== 1'b0 || txd !== 1'b1) busy_err++;
         end
         chk({tag, "_no_queue"}, busy_err, 0);
      end
   endtask

   initial begin
      int lat;
      int bad;
      vecs[0] = '{8'h00, 8'h22, 5'd0, 32'h0,        7,
                  {8'hBB,8'h00,8'h22,8'h00,8'h00,8'h22,8'h7E,32'h0}};
      vecs[1] = '{8'h00, 8'h27, 5'd3, 32'h000A0022, 10,
                  {8'hBB,8'h00,8'h27,8'h00,8'h03,8'h22,8'h00,8'h0A,8'h56,8'h7E,8'h00}};
      vecs[2] = '{8'h00, 8'hFF, 5'd2, 32'h0000FFFF, 9,
                  {8'hBB,8'h00,8'hFF,8'h00,8'h02,8'hFF,8'hFF,8'hFF,8'h7E,16'h0}};
      vecs[3] = '{8'h00, 8'h22, 5'd9, 32'h44332211, 11,
                  {8'hBB,8'h00,8'h22,8'h00,8'h04,8'h11,8'h22,8'h33,8'h44,8'hD0,8'h7E}};
      vecs[4] = '{8'h01, 8'h0F, 5'd1, 32'hAABBCCF5, 8,
                  {8'hBB,8'h01,8'h0F,8'h00,8'h01,8'hF5,8'h06,8'h7E,24'h0}};

      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("reset_txd", {31'd0, txd}, 32'd1);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);

      for (int k = 0; k < 5; k++) begin
         repeat (5) @(negedge clk);
         pulse_start(vecs[k]);
         chk($sformatf("v%0d_busy_latch", k), {31'd0, busy}, 32'd1);
         check_frame($sformatf("v%0d", k), vecs[k], 1'b0, lat);
      end

      // start mid-frame and in the done clock are both ignored
      repeat (5) @(negedge clk);
      pulse_start(vecs[1]);
      check_frame("midstart", vecs[1], 1'b1, lat);

      // start in the same clk as baud_tick: latch only, start bit one tick later
      lat = 0;
      @(posedge clk);
      while (baud_tick !== 1'b1 && lat < 40) begin
         @(posedge clk);
         lat++;
      end
      chk("tick_align_found", {31'd0, baud_tick}, 32'd1);
      repeat (15) @(posedge clk);
      @(negedge clk);
      pulse_start(vecs[0]);
      chk("coincide_txd_high", {31'd0, txd}, 32'd1);
      chk("coincide_busy", {31'd0, busy}, 32'd1);
      check_frame("coincide", vecs[0], 1'b0, lat);
      chk("coincide_latency", lat, 16);

      // reset during byte 3, bit 4
      repeat (5) @(negedge clk);
      pulse_start(vecs[1]);
      lat = 0;
      while (txd !== 1'b0 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      repeat (568) @(negedge clk);
      chk("rst_pre_bit", {30'd0, txd, busy}, 32'd1);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_txd", {31'd0, txd}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      end
      chk("rst_aborted", bad, 0);
      pulse_start(vecs[1]);
      chk("post_rst_busy", {31'd0, busy}, 32'd1);
      check_frame("post_rst", vecs[1], 1'b0, lat);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
